// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver FSM states and 8N1 framing constants.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, full/empty flags and a one-cycle overflow pulse.
// Latency: a write is visible (count/empty) the next cycle; a write while full is dropped and never blocks.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic                  rd_pop,
  output logic [WIDTH-1:0]      rd_dat,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);
  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;

  // Flags come from the registered count, so a pop cannot make room for a same-cycle write.
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign push     = wr_vld && !full;
  assign pop      = rd_pop && !empty;
  assign rd_dat   = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_vld && full;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: strobed bytes queue in a FIFO and leave LSB-first, one bit per baud tick.
// Latency: start bit on the first tick after the byte is queued; a strobe while full is dropped and flagged.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 baud_x1,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_strobe,
  output logic                 serial,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 overflow,
  output logic [DEPTH_LOG2:0]  count
);
  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] head;
  logic                 pop;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;

  sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (mclk),
    .rst      (reset),
    .wr_vld   (data_strobe),
    .wr_dat   (data),
    .rd_pop   (pop),
    .rd_dat   (head),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    pop      = 1'b0;
    if (baud_x1) begin
      case (state_q)
        IDLE, STOP: begin
          // STOP falls straight into the next start bit when more bytes wait.
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = head;
            serial_d = UART_START_BIT;
            busy_d   = 1'b1;
            state_d  = START;
          end else begin
            serial_d = UART_STOP_BIT;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
        START: begin
          serial_d = shift_q[0];
          idx_d    = '0;
          state_d  = DATA;
        end
        DATA: begin
          if (idx_q == LAST_IDX) begin
            serial_d = UART_STOP_BIT;
            state_d  = STOP;
          end else begin
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
            idx_d    = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      serial_q <= UART_STOP_BIT;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
    end
  end

  assign serial = serial_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered: framing, bursts, overflow, wrap, push/pop race, reset abort.
module tb_uart_tx_buffered;
  logic       mclk;
  logic       reset;
  logic       baud_x1;
  logic [7:0] data;
  logic       data_strobe;
  logic       serial, full, empty, busy, overflow;
  logic [4:0] count;

  int n_run  = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  bit baud_en = 0;
  bit baud_force = 0;
  int baud_div = 16;
  int div_cnt = 0;

  uart_tx_buffered #(.DEPTH_LOG2(4), .DATA_BITS(8)) dut (
    .mclk        (mclk),
    .reset       (reset),
    .baud_x1     (baud_x1),
    .data        (data),
    .data_strobe (data_strobe),
    .serial      (serial),
    .full        (full),
    .empty       (empty),
    .busy        (busy),
    .overflow    (overflow),
    .count       (count)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Baud enable changes on the falling edge so it is stable when the DUT samples it.
  initial begin
    baud_x1 = 1'b0;
    forever begin
      @(negedge mclk);
      if (baud_en) begin
        if (div_cnt >= baud_div - 1) begin
          baud_x1 = 1'b1;
          div_cnt = 0;
        end else begin
          baud_x1 = 1'b0;
          div_cnt++;
        end
      end else begin
        baud_x1 = baud_force;
        div_cnt = 0;
      end
    end
  end

  always @(posedge mclk) if (baud_x1) tick_cnt++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    data        = b;
    data_strobe = 1'b1;
    cyc(1);
    data_strobe = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge mclk);
      if (baud_x1) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  // Captures one frame as {stop, d7..d0, start}; started=1 means the start bit is already on the line.
  task automatic recv_frame(input bit started, output logic [9:0] fr, output int st);
    bit ok;
    int misses;
    ok     = started;
    misses = 0;
    fr     = '0;
    if (!started) begin
      for (int i = 0; i < 400; i++) begin
        cyc(1);
        if (serial === 1'b0) begin
          ok = 1'b1;
          break;
        end
      end
    end
    chk("start_seen", 32'(ok), 32'd1);
    fr[0] = serial;
    st    = tick_cnt;
    for (int i = 1; i < 10; i++) begin
      wait_tick(ok);
      if (!ok) misses++;
      fr[i] = serial;
    end
    chk("tick_timeout", 32'(misses), 32'd0);
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] v;
    int         st0, st1, st2;
    int         bad;
    bit         ok;

    reset       = 1'b1;
    data        = 8'h00;
    data_strobe = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_serial",   32'(serial),   32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_count",    32'(count),    32'd0);

    // Single byte 0xA5 at one tick per 16 mclk: line must read 0,1,0,1,0,0,1,0,1,1.
    baud_div = 16;
    push(8'hA5);
    chk("a5_count", 32'(count), 32'd1);
    chk("a5_empty", 32'(empty), 32'd0);
    baud_en = 1'b1;
    recv_frame(1'b0, fr, st0);
    chk("a5_frame", 32'(fr), 32'h34A);
    wait_tick(ok);
    chk("a5_busy_after",  32'(busy),  32'd0);
    chk("a5_empty_after", 32'(empty), 32'd1);
    chk("a5_idle_line",   32'(serial), 32'd1);

    // Three bytes on consecutive cycles go out as 30 contiguous bit periods.
    baud_en = 1'b0;
    cyc(2);
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    chk("b2b_count3", 32'(count), 32'd3);
    baud_en = 1'b1;
    recv_frame(1'b0, fr, st0);
    chk("b2b_frame0", 32'(fr), 32'h200);
    chk("b2b_count2", 32'(count), 32'd2);
    recv_frame(1'b0, fr, st1);
    chk("b2b_frame1", 32'(fr), 32'h3FE);
    chk("b2b_count1", 32'(count), 32'd1);
    recv_frame(1'b0, fr, st2);
    chk("b2b_frame2", 32'(fr), 32'h2AA);
    chk("b2b_count0", 32'(count), 32'd0);
    chk("b2b_gap01", 32'(st1 - st0), 32'd10);
    chk("b2b_gap12", 32'(st2 - st1), 32'd10);
    wait_tick(ok);
    chk("b2b_busy_after", 32'(busy), 32'd0);

    // Seventeen strobes with no ticks: the last one is dropped and flagged for exactly one cycle.
    baud_en = 1'b0;
    cyc(2);
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("ovf_full",     32'(full),     32'd1);
    chk("ovf_count16",  32'(count),    32'd16);
    chk("ovf_quiet",    32'(overflow), 32'd0);
    push(8'h10);
    chk("ovf_pulse",    32'(overflow), 32'd1);
    chk("ovf_count",    32'(count),    32'd16);
    cyc(1);
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    baud_div = 1;
    baud_en  = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      recv_frame(1'b0, fr, st0);
      if (fr !== {1'b1, 8'(i), 1'b0}) bad++;
    end
    chk("ovf_drain_order", 32'(bad), 32'd0);
    cyc(30);
    chk("ovf_no_0x10", 32'(busy),  32'd0);
    chk("ovf_empty",   32'(empty), 32'd1);

    // Forty bytes in bursts of ten carry the pointers around the ring more than once.
    bad = 0;
    for (int b = 0; b < 4; b++) begin
      baud_en = 1'b0;
      cyc(3);
      for (int i = 0; i < 10; i++) push(8'((b * 10 + i) * 37 + 1));
      baud_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
        recv_frame(1'b0, fr, st0);
        v = 8'((b * 10 + i) * 37 + 1);
        if (fr !== {1'b1, v, 1'b0}) begin
          bad++;
          $display("FAIL wrap_byte%0d: observed %0h expected %0h", b * 10 + i, fr[8:1], v);
        end
      end
    end
    chk("wrap_errors", 32'(bad), 32'd0);

    // Strobe on the very tick that pops the head out of IDLE.
    cyc(3);
    baud_en = 1'b0;
    cyc(2);
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    cyc(1);
    chk("sim_count_before", 32'(count), 32'd5);
    chk("sim_idle",         32'(busy),  32'd0);
    data        = 8'h16;
    data_strobe = 1'b1;
    baud_force  = 1'b1;
    cyc(1);
    data_strobe = 1'b0;
    baud_force  = 1'b0;
    chk("sim_count_same", 32'(count),  32'd5);
    chk("sim_busy",       32'(busy),   32'd1);
    chk("sim_start_bit",  32'(serial), 32'd0);
    baud_div = 1;
    baud_en  = 1'b1;
    recv_frame(1'b1, fr, st0);
    chk("sim_first_byte", 32'(fr), 32'h222);
    bad = 0;
    for (int i = 1; i < 6; i++) begin
      recv_frame(1'b0, fr, st0);
      if (fr !== {1'b1, 8'(8'h11 + i), 1'b0}) bad++;
    end
    chk("sim_rest_order", 32'(bad), 32'd0);

    // Reset during data bit 3 of 0x3C with four bytes behind it.
    cyc(3);
    baud_en = 1'b0;
    cyc(2);
    push(8'h3C);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    baud_div = 16;
    baud_en  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      if (serial === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rmf_start_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 4; i++) wait_tick(ok);
    chk("rmf_bit3",  32'(serial), 32'd1);
    chk("rmf_queue", 32'(count),  32'd4);
    chk("rmf_busy",  32'(busy),   32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rmf_serial", 32'(serial), 32'd1);
    chk("rmf_busy0",  32'(busy),   32'd0);
    chk("rmf_count0", 32'(count),  32'd0);
    chk("rmf_empty",  32'(empty),  32'd1);
    data        = 8'hAA;
    data_strobe = 1'b1;
    cyc(2);
    data_strobe = 1'b0;
    reset       = 1'b0;
    cyc(1);
    chk("rmf_strobe_in_reset", 32'(count), 32'd0);
    bad = 0;
    repeat (80) begin
      cyc(1);
      if (serial !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rmf_quiet", 32'(bad), 32'd0);
    push(8'h5A);
    recv_frame(1'b0, fr, st0);
    chk("rmf_new_frame", 32'(fr), 32'h2B4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
